// File: rtl/i2c_arbiter.sv
// ============================================================================
// Module      : i2c_arbiter
// Description : Two-requester round-robin front end for a single I2C master,
//               with transaction field latching, completion and timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clock_freq,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       rw_0,
  input  logic       rw_1,
  input  logic [6:0] dev_id_0,
  input  logic [6:0] dev_id_1,
  input  logic [7:0] addr_0,
  input  logic [7:0] addr_1,
  input  logic [7:0] wdata_0,
  input  logic [7:0] wdata_1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       timeout,
  output logic       m_start,
  output logic [6:0] m_dev_id,
  output logic [7:0] m_addr,
  output logic [7:0] m_data,
  output logic       m_rw,
  output logic       m_abort,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_rdata
);

  localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          to_q, to_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rw_q, rw_d;
  logic          w_win;
  logic          w_limit;

  // last_q doubles as the current owner once a transaction has been issued
  always_comb begin
    w_win = ~last_q;
    case (req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      default: w_win = ~last_q;
    endcase
  end

  assign w_limit = (cnt_q == CNT_LAST);

  always_ff @(posedge clock_freq) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= 8'h00;
      dev_q   <= 7'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      dev_q   <= dev_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    dev_d   = dev_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d = ST_ISSUE;
          last_d  = w_win;
          if (w_win) begin
            rw_d = rw_1; dev_d = dev_id_1; addr_d = addr_1; data_d = wdata_1;
          end else begin
            rw_d = rw_0; dev_d = dev_id_0; addr_d = addr_0; data_d = wdata_0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // a completion in the limit cycle takes precedence over the abort
        if (m_done) begin
          state_d = ST_DONE;
          err_d   = m_nack;
          to_d    = 1'b0;
          if (rw_q) rdata_d = m_rdata;
        end else if (w_limit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant   = 2'b00;
    done    = 2'b00;
    m_start = 1'b0;
    m_abort = 1'b0;
    err     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        grant[last_q] = 1'b1;
        m_start       = 1'b1;
      end
      ST_WAIT: begin
        grant[last_q] = 1'b1;
        m_abort       = ~m_done & w_limit & ~reset;
      end
      ST_DONE: begin
        grant[last_q] = 1'b1;
        done[last_q]  = 1'b1;
        err           = err_q;
        timeout       = to_q;
      end
      default: ;
    endcase
  end

  assign rdata    = rdata_q;
  assign m_dev_id = dev_q;
  assign m_addr   = addr_q;
  assign m_data   = data_q;
  assign m_rw     = rw_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Directed bench for i2c_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic       rw_0, rw_1;
  logic [6:0] dev_id_0, dev_id_1;
  logic [7:0] addr_0, addr_1, wdata_0, wdata_1;
  logic [1:0] grant, done;
  logic [7:0] rdata;
  logic       err, timeout, m_start, m_rw, m_abort;
  logic [6:0] m_dev_id;
  logic [7:0] m_addr, m_data;
  logic       m_done, m_nack;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  i2c_arbiter #(.TIMEOUT(TO)) dut (
    .clock_freq(clk), .reset(reset), .req(req),
    .rw_0(rw_0), .rw_1(rw_1), .dev_id_0(dev_id_0), .dev_id_1(dev_id_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .grant(grant), .done(done), .rdata(rdata), .err(err), .timeout(timeout),
    .m_start(m_start), .m_dev_id(m_dev_id), .m_addr(m_addr), .m_data(m_data),
    .m_rw(m_rw), .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit active = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: owner (-1 = none), cycles since grant, finishing flag
  int         owner = -1;
  int         cyc = 0;
  bit         fin = 0;
  bit         lastp = 1;
  logic [7:0] e_rdata, e_addr, e_data;
  logic [6:0] e_dev;
  logic       e_rw, e_err, e_to;

  always @(posedge clk) begin
    if (reset) begin
      owner = -1; fin = 0; lastp = 1; cyc = 0;
      e_rdata = 0; e_dev = 0; e_addr = 0; e_data = 0; e_rw = 0; e_err = 0; e_to = 0;
    end else if (owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b01) owner = 0;
        else if (req == 2'b10) owner = 1;
        else owner = lastp ? 0 : 1;
        lastp = (owner == 1);
        cyc = 1;
        if (owner == 0) {e_rw, e_dev, e_addr, e_data} = {rw_0, dev_id_0, addr_0, wdata_0};
        else            {e_rw, e_dev, e_addr, e_data} = {rw_1, dev_id_1, addr_1, wdata_1};
      end
    end else if (fin) begin
      owner = -1; fin = 0;
    end else if (cyc >= 2 && m_done) begin
      fin = 1; e_err = m_nack; e_to = 0;
      if (e_rw) e_rdata = m_rdata;
    end else if (cyc == TO + 1) begin
      fin = 1; e_err = 1; e_to = 1;
    end else begin
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    if (active) begin
      eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      chk("grant",   grant,   eg);
      chk("done",    done,    fin ? eg : 2'b00);
      chk("m_start", m_start, owner >= 0 && !fin && cyc == 1);
      chk("m_abort", m_abort, owner >= 0 && !fin && cyc == TO + 1 && !m_done && !reset);
      chk("timeout", timeout, fin && e_to);
      if (fin) chk("err", err, e_err);
      chk("rdata",    rdata,    e_rdata);
      chk("m_dev_id", m_dev_id, e_dev);
      chk("m_addr",   m_addr,   e_addr);
      chk("m_data",   m_data,   e_data);
      chk("m_rw",     m_rw,     e_rw);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_start();
    int k = 0;
    do begin
      tick(1);
      k++;
    end while (!m_start && k < 20);
    chk("start_seen", m_start, 1'b1);
  endtask

  task automatic pulse_done(input logic nack, input logic [7:0] rd);
    m_done = 1; m_nack = nack; m_rdata = rd;
    tick(1);
    m_done = 0; m_nack = 0; m_rdata = 8'h00;
  endtask

  logic [1:0] seen [3];
  int         n_abort;

  initial begin
    reset = 1; req = 0; rw_0 = 0; rw_1 = 0; dev_id_0 = 0; dev_id_1 = 0;
    addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
    m_done = 0; m_nack = 0; m_rdata = 0;
    @(posedge clk); #2;
    active = 1;
    chk("reset_grant", grant, 2'b00);
    chk("reset_rdata", rdata, 8'h00);
    tick(1);
    reset = 0;

    // Tie after reset: requester 0 first, then alternating
    req = 2'b11; dev_id_0 = 7'h11; dev_id_1 = 7'h22;
    for (int g = 0; g < 3; g++) begin
      wait_start();
      seen[g] = grant;
      tick(2);
      pulse_done(1'b0, 8'h00);
      if (g == 2) req = 2'b00;
    end
    chk("tie_grant0", seen[0], 2'b01);
    chk("tie_grant1", seen[1], 2'b10);
    chk("tie_grant2", seen[2], 2'b01);
    tick(2);

    // Single read; req withdrawn and fields changed after latching
    req = 2'b01; rw_0 = 1; dev_id_0 = 7'h48; addr_0 = 8'h10;
    wait_start();
    req = 2'b00; dev_id_0 = 7'h7F; addr_0 = 8'hEE;
    tick(2);
    pulse_done(1'b0, 8'hA5);
    chk("rd_done",  done,     2'b01);
    chk("rd_rdata", rdata,    8'hA5);
    chk("rd_err",   err,      1'b0);
    chk("rd_dev",   m_dev_id, 7'h48);
    chk("rd_addr",  m_addr,   8'h10);
    tick(2);

    // NACKed write from requester 1
    req = 2'b10; rw_1 = 0; wdata_1 = 8'h3C; addr_1 = 8'h05;
    wait_start();
    req = 2'b00;
    tick(1);
    pulse_done(1'b1, 8'hFF);
    chk("nack_done",  done,    2'b10);
    chk("nack_err",   err,     1'b1);
    chk("nack_to",    timeout, 1'b0);
    chk("nack_rdata", rdata,   8'hA5);
    chk("nack_data",  m_data,  8'h3C);
    tick(2);

    // Timeout: master never completes
    req = 2'b01; rw_0 = 1;
    wait_start();
    req = 2'b00;
    n_abort = 0;
    do begin
      tick(1);
      n_abort++;
    end while (!m_abort && n_abort < 20);
    chk("abort_cycles", n_abort, TO);
    tick(1);
    chk("to_done",  done,    2'b01);
    chk("to_err",   err,     1'b1);
    chk("to_flag",  timeout, 1'b1);
    chk("to_rdata", rdata,   8'hA5);
    tick(2);

    // Completion in the limit cycle wins over abort
    req = 2'b10; rw_1 = 1;
    wait_start();
    req = 2'b00;
    tick(TO);
    m_done = 1; m_rdata = 8'h5A;
    #1;
    chk("race_abort", m_abort, 1'b0);
    tick(1);
    m_done = 0; m_rdata = 8'h00;
    chk("race_to",    timeout, 1'b0);
    chk("race_rdata", rdata,   8'h5A);
    tick(2);

    // Reset during WAIT abandons the transaction silently
    req = 2'b10;
    wait_start();
    req = 2'b00;
    tick(2);
    reset = 1;
    tick(1);
    reset = 0;
    chk("rst_grant", grant, 2'b00);
    chk("rst_done",  done,  2'b00);
    tick(3);
    req = 2'b01; rw_0 = 0;
    wait_start();
    chk("post_rst_grant", grant, 2'b01);
    req = 2'b00;
    tick(1);
    pulse_done(1'b0, 8'h00);
    tick(3);

    active = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, sets the number of WAIT-state cycles without m_done before a transaction is aborted.
REQ-002 clock_freq  in  1  sole clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester transaction request, level; bit i = requester i.
REQ-005 rw_0, rw_1  in  1 each  1 = read, 0 = write.
REQ-006 dev_id_0, dev_id_1  in  7 each  target I2C device address.
REQ-007 addr_0, addr_1  in  8 each  target register address.
REQ-008 wdata_0, wdata_1  in  8 each  write data.
REQ-009 grant  out  2  one-hot-or-zero; bit i high while requester i owns the master.
REQ-010 done  out  2  one-cycle completion pulse to the granted requester.
REQ-011 rdata  out  8  read data; valid in the done cycle.
REQ-012 err  out  1  error flag; valid in the done cycle (NACK or timeout).
REQ-013 timeout  out  1  high in the done cycle only when the transaction timed out.
REQ-014 m_start  out  1  one-cycle start pulse to the I2C master.
REQ-015 m_dev_id (7), m_addr (8), m_data (8), m_rw (1)  out  latched transaction fields to the master.
REQ-016 m_abort  out  1  one-cycle pulse forcing the master back to ready on timeout.
REQ-017 m_done  in  1  master completion pulse; m_nack  in  1  slave NACK seen, sampled with m_done; m_rdata  in  8  read byte, sampled with m_done.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; any other encoding SHALL return to IDLE next cycle.
REQ-019 IDLE: if req != 0, select a winner and go to ISSUE; otherwise stay in IDLE.
REQ-020 Arbitration: round-robin pointer `last`; when only one bit of req is set, grant that requester; when both are set, grant the requester != last; `last` updates to the winner on entry to ISSUE.
REQ-021 On the IDLE->ISSUE transition, latch the winner's rw/dev_id/addr/wdata into m_rw/m_dev_id/m_addr/m_data; these SHALL hold until the next ISSUE.
REQ-022 ISSUE: exactly one cycle; grant[winner]=1; m_start=1; timeout counter cleared; next state WAIT.
REQ-023 m_done is ignored in ISSUE and only sampled in WAIT.
REQ-024 WAIT: grant held; counter increments each cycle; m_done=1 -> DONE with err<=m_nack and timeout<=0; if m_rw=1, rdata<=m_rdata.
REQ-025 WAIT, counter reaching TIMEOUT without m_done: m_abort=1 that cycle; go to DONE with err=1, timeout=1, rdata unchanged.
REQ-026 m_done and counter==TIMEOUT in the same cycle: m_done wins; no abort.
REQ-027 DONE: exactly one cycle; done[winner]=1 with grant still high; next state IDLE; grant drops on entry to IDLE.
REQ-028 Latency: req sampled in IDLE at cycle t -> grant/m_start at t+1; m_done at t_d -> done at t_d+1; earliest re-grant at t_d+3.
REQ-029 Withdrawal of req during ISSUE/WAIT does not cancel the transaction; done is still pulsed.
REQ-030 Input field changes after latching have no effect on the current transaction.
REQ-031 rdata is updated only on a successful or NACKed read completion; it is unchanged on writes and timeouts.
REQ-032 done, m_start, m_abort, timeout are never high outside their stated single cycle.

Reset
REQ-033 With reset=1 at a posedge: state=IDLE, grant=0, done=0, err=0, timeout=0, m_start=0, m_abort=0, rdata=0x00, m_* fields=0, counter=0, last=1 (requester 0 wins first tie).
REQ-034 Reset mid-transaction abandons it without a done pulse and without m_abort; reset has priority over all other events.

Verification
REQ-035 Single read: req=01, rw_0=1, dev_id_0=0x48, addr_0=0x10; m_done with m_rdata=0xA5 three cycles after m_start -> done=01, rdata=0xA5, err=0, m_dev_id=0x48, m_addr=0x10.
REQ-036 Tie after reset: req=11 held -> first grant=01, then grant=10, then 01; m_start once per grant.
REQ-037 NACK write: req=10, rw_1=0, wdata_1=0x3C; m_done with m_nack=1 -> done=10, err=1, timeout=0, rdata unchanged.
REQ-038 Timeout: TIMEOUT=8, m_done never asserted -> m_abort pulse after 8 WAIT cycles, then done pulse with err=1, timeout=1; the next request is granted normally.
REQ-039 Reset in WAIT: assert reset for one cycle -> grant=0 next cycle, no done, no m_abort; req=01 afterwards is granted to requester 0.
